// File: rtl/setting_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : setting_bus_pkg
//  Description : Shared constants for the AXI-stream to settings-bus bridge:
//                FSM state encodings, header field positions, data width and
//                a helper that builds the reserved-field mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package setting_bus_pkg;

    // Settings-bus data width
    localparam int c_DATA_W = 32;

    // Header field positions
    localparam int c_AUTO_INC_BIT = 31;
    localparam int c_RSVD_HI_BIT  = 30;

    // FSM state encodings
    localparam logic [1:0] S_HDR  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Mask covering header bits [c_RSVD_HI_BIT:aw]; these must be zero
    function automatic logic [31:0] rsvd_mask(input int aw);
        logic [31:0] w_hi;
        logic [31:0] w_lo;
        w_hi = (32'h1 << (c_RSVD_HI_BIT + 1)) - 32'h1;
        w_lo = (32'h1 << aw) - 32'h1;
        return w_hi & ~w_lo;
    endfunction

endpackage : setting_bus_pkg
`default_nettype wire

// File: rtl/strobe_gap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : strobe_gap_counter
//  Description : Down-counter that enforces a minimum idle gap between
//                settings-bus strobes. Loads GAP, counts down to zero and
//                holds there; zero means the next write may be accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module strobe_gap_counter #(
    parameter int GAP = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    output logic zero
);

    localparam int c_W = $clog2(GAP + 1);

    logic [c_W-1:0] r_cnt;

    // Load on a write, otherwise count down until zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_W'(GAP);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_W'(1);
        end
    end

    assign zero = (r_cnt == '0);

endmodule : strobe_gap_counter
`default_nettype wire

// File: rtl/axi_stream_to_setting_bus.sv
`default_nettype none
// ============================================================================
//  Module      : axi_stream_to_setting_bus
//  Description : Settings-bus initiator. Word 0 of each AXI-stream packet is
//                a header (start address, AUTO_INC flag); each following word
//                becomes one registered set_stb write, optionally throttled
//                to a minimum inter-strobe gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_to_setting_bus
    import setting_bus_pkg::*;
#(
    parameter int AWIDTH     = 8,
    parameter int STROBE_GAP = 0,
    parameter int CHECK_RSVD = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [c_DATA_W-1:0] i_tdata,
    input  logic                i_tlast,
    input  logic                i_tvalid,
    output logic                i_tready,
    output logic                set_stb,
    output logic [AWIDTH-1:0]   set_addr,
    output logic [c_DATA_W-1:0] set_data,
    output logic                error_stb,
    output logic                busy
);

    localparam logic [31:0] c_RSVD_MASK = rsvd_mask(AWIDTH);

    logic [1:0]        r_state;
    logic [AWIDTH-1:0] r_addr;
    logic              r_auto_inc;
    logic              r_run;

    logic w_beat;
    logic w_data_fire;
    logic w_rsvd_bad;
    logic w_gap_zero;

    assign w_beat      = i_tvalid & i_tready;
    assign w_data_fire = w_beat && (r_state == S_DATA);
    assign w_rsvd_bad  = (CHECK_RSVD != 0) && ((i_tdata & c_RSVD_MASK) != 32'h0);

    // Ready is held low through reset, then gated only by the gap counter.
    // The counter is zero in S_HDR/S_DROP except right after a final data
    // beat, which is exactly when the next header must wait.
    assign i_tready = r_run & w_gap_zero;

    generate
        if (STROBE_GAP > 0) begin : g_gap
            strobe_gap_counter #(
                .GAP (STROBE_GAP)
            ) u_gap (
                .clk     (clk),
                .reset_n (reset_n),
                .load    (w_data_fire),
                .zero    (w_gap_zero)
            );
        end else begin : g_no_gap
            assign w_gap_zero = 1'b1;
        end
    endgenerate

    // Packet FSM, address tracking and registered settings-bus outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_HDR;
            r_addr     <= '0;
            r_auto_inc <= 1'b0;
            r_run      <= 1'b0;
            set_stb    <= 1'b0;
            set_addr   <= '0;
            set_data   <= '0;
            error_stb  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            set_stb   <= 1'b0;
            error_stb <= 1'b0;
            case (r_state)
                S_HDR: begin
                    if (w_beat) begin
                        r_addr     <= i_tdata[AWIDTH-1:0];
                        r_auto_inc <= i_tdata[c_AUTO_INC_BIT];
                        if (w_rsvd_bad) begin
                            // Bad header: flag it and swallow the rest
                            error_stb <= 1'b1;
                            r_state   <= i_tlast ? S_HDR : S_DROP;
                            busy      <= ~i_tlast;
                        end else if (i_tlast) begin
                            // Header with no data words is malformed
                            error_stb <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                            busy    <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        set_stb  <= 1'b1;
                        set_addr <= r_addr;
                        set_data <= i_tdata;
                        if (r_auto_inc) begin
                            r_addr <= r_addr + AWIDTH'(1);
                        end
                        if (i_tlast) begin
                            r_state <= S_HDR;
                            busy    <= 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (w_beat && i_tlast) begin
                        r_state <= S_HDR;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_HDR;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule : axi_stream_to_setting_bus
`default_nettype wire

// File: tb/tb_axi_stream_to_setting_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_stream_to_setting_bus
//  Description : Scoreboard bench. Three instances (gap 0, 3, 1) share a
//                reset; drivers push expected writes, one monitor pops and
//                compares every strobe and error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_to_setting_bus;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [31:0] tdata  [3];
    logic        tlast  [3];
    logic        tvalid [3];
    logic        tready [3];
    logic        stb    [3];
    logic [7:0]  addr   [3];
    logic [31:0] data   [3];
    logic        err    [3];
    logic        busy   [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            axi_stream_to_setting_bus #(
                .AWIDTH     (8),
                .STROBE_GAP ((gi == 0) ? 0 : ((gi == 1) ? 3 : 1)),
                .CHECK_RSVD (1)
            ) u_dut (
                .clk       (clk),
                .reset_n   (reset_n),
                .i_tdata   (tdata[gi]),
                .i_tlast   (tlast[gi]),
                .i_tvalid  (tvalid[gi]),
                .i_tready  (tready[gi]),
                .set_stb   (stb[gi]),
                .set_addr  (addr[gi]),
                .set_data  (data[gi]),
                .error_stb (err[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    typedef struct {
        int          inst;
        logic [7:0]  a;
        logic [31:0] d;
        longint      cyc;
    } exp_t;

    exp_t   q[$];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    int     err_seen [3] = '{0, 0, 0};
    int     exp_err  [3] = '{0, 0, 0};
    int     stb_cnt  [3] = '{0, 0, 0};
    longint last_stb [3] = '{-1, -1, -1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Present one beat and hold it until the DUT is ready (bounded wait)
    task automatic send(input int i, input logic [31:0] d, input logic last,
                        input logic exp_wr, input logic [7:0] a, output int waited);
        @(negedge clk);
        tdata[i]  = d;
        tlast[i]  = last;
        tvalid[i] = 1'b1;
        waited    = 0;
        while (!tready[i] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!tready[i]) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout inst %0d actual 0 required 1", i);
        end
        if (exp_wr) q.push_back('{i, a, d, cyc + 1});
    endtask

    task automatic idle(input int i);
        @(negedge clk);
        tvalid[i] = 1'b0;
        tlast[i]  = 1'b0;
    endtask

    task automatic check_zero(input int i);
        check("rst_stb",   stb[i],    0);
        check("rst_addr",  addr[i],   0);
        check("rst_data",  data[i],   0);
        check("rst_err",   err[i],    0);
        check("rst_busy",  busy[i],   0);
        check("rst_ready", tready[i], 0);
    endtask

    // Monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (stb[i] || err[i]) check("stb_err_excl", stb[i] & err[i], 0);
            if (err[i]) err_seen[i]++;
            if (stb[i]) begin
                stb_cnt[i]++;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe inst %0d addr %0h data %0h required none",
                             i, addr[i], data[i]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("wr_inst", i, e.inst);
                    check("wr_addr", addr[i], e.a);
                    check("wr_data", data[i], e.d);
                    check("wr_latency", cyc, e.cyc);
                end
                if (last_stb[i] >= 0) begin
                    if (i == 1) check("gap_exact", cyc - last_stb[i], 4);
                    else check("gap_min", longint'((cyc - last_stb[i]) >= ((i == 2) ? 2 : 1)), 1);
                end
                last_stb[i] = cyc;
            end
        end
    end

    initial begin
        int w;
        for (int i = 0; i < 3; i++) begin
            tdata[i] = '0; tlast[i] = 1'b0; tvalid[i] = 1'b0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i);
        reset_n = 1'b1;
        @(negedge clk);

        // Burst with auto-increment, gap 0
        check("busy_idle", busy[0], 0);
        send(0, 32'h8000_0010, 1'b0, 1'b0, 8'h00, w);
        send(0, 32'h0000_000A, 1'b0, 1'b1, 8'h10, w);
        check("busy_in_pkt", busy[0], 1);
        send(0, 32'h0000_000B, 1'b0, 1'b1, 8'h11, w);
        check("busy_in_pkt2", busy[0], 1);
        send(0, 32'h0000_000C, 1'b1, 1'b1, 8'h12, w);
        idle(0);
        check("busy_after_last", busy[0], 0);

        // Fixed address with gap 3 and tvalid held high
        send(1, 32'h0000_0042, 1'b0, 1'b0, 8'h00, w);
        send(1, 32'h0000_0001, 1'b0, 1'b1, 8'h42, w);
        check("gap3_wait_first", w, 0);
        send(1, 32'h0000_0002, 1'b0, 1'b1, 8'h42, w);
        check("gap3_wait_2", w, 3);
        send(1, 32'h0000_0003, 1'b1, 1'b1, 8'h42, w);
        check("gap3_wait_3", w, 3);
        idle(1);

        // Address wrap
        send(0, 32'h8000_00FE, 1'b0, 1'b0, 8'h00, w);
        send(0, 32'h0000_0011, 1'b0, 1'b1, 8'hFE, w);
        send(0, 32'h0000_0022, 1'b0, 1'b1, 8'hFF, w);
        send(0, 32'h0000_0033, 1'b0, 1'b1, 8'h00, w);
        send(0, 32'h0000_0044, 1'b1, 1'b1, 8'h01, w);
        idle(0);
        repeat (2) @(negedge clk);
        check("wrap_no_err", err_seen[0], exp_err[0]);

        // Reserved bit set -> dropped packet, then a normal packet
        send(0, 32'h0100_0005, 1'b0, 1'b0, 8'h00, w);
        exp_err[0]++;
        send(0, 32'h0000_00D1, 1'b0, 1'b0, 8'h00, w);
        check("drop_busy", busy[0], 1);
        send(0, 32'h0000_00D2, 1'b1, 1'b0, 8'h00, w);
        send(0, 32'h8000_0030, 1'b0, 1'b0, 8'h00, w);
        send(0, 32'h0000_0005, 1'b0, 1'b1, 8'h30, w);
        send(0, 32'h0000_0006, 1'b1, 1'b1, 8'h31, w);
        // Header-only packet
        send(0, 32'h8000_0070, 1'b1, 1'b0, 8'h00, w);
        exp_err[0]++;
        idle(0);
        check("hdr_only_busy", busy[0], 0);
        repeat (2) @(negedge clk);
        check("malformed_errs", err_seen[0], exp_err[0]);

        // Reset mid-packet
        send(0, 32'h8000_0050, 1'b0, 1'b0, 8'h00, w);
        send(0, 32'h0000_0077, 1'b0, 1'b1, 8'h50, w);
        idle(0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_zero(0);
        reset_n = 1'b1;
        send(0, 32'h8000_0020, 1'b0, 1'b0, 8'h00, w);
        send(0, 32'h0000_0099, 1'b1, 1'b1, 8'h20, w);
        idle(0);

        // Idle gaps inside a burst, gap 1
        send(2, 32'h8000_0060, 1'b0, 1'b0, 8'h00, w);
        for (int k = 0; k < 5; k++) begin
            repeat ($urandom_range(0, 2)) idle(2);
            send(2, 32'h0000_0100 + k, (k == 4), 1'b1, 8'h60 + 8'(k), w);
        end
        idle(2);

        repeat (10) @(negedge clk);
        check("queue_empty", q.size(), 0);
        check("stb_cnt0", stb_cnt[0], 11);
        check("stb_cnt1", stb_cnt[1], 3);
        check("stb_cnt2", stb_cnt[2], 5);
        for (int i = 0; i < 3; i++) check("err_cnt", err_seen[i], exp_err[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_axi_stream_to_setting_bus
`default_nettype wire

// File: doc/axi_stream_to_setting_bus.md
Name: axi_stream_to_setting_bus

Overview:
- Initiator for the settings bus. Consumes AXI-stream command packets and issues `set_stb`/`set_addr`/`set_data` writes.
- Sits between a host/command-packet path and any set of settings-bus register consumers.
- Packet format:
  - Word 0 is a header: start address plus auto-increment flag.
  - Each following word is one register write.
- Write rate is throttleable so slow consumers see a guaranteed minimum inter-strobe gap.

Parameters:
- AWIDTH, 8, settings-bus address width (1..24).
- STROBE_GAP, 0, minimum idle cycles between consecutive `set_stb` pulses (0 = back-to-back).
- CHECK_RSVD, 1, 1 = header with nonzero reserved bits is rejected and the packet dropped.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- i_tdata  in  32  command stream data
- i_tlast  in  1  last word of command packet
- i_tvalid  in  1  stream valid
- i_tready  out  1  stream ready
- set_stb  out  1  settings write strobe, one cycle
- set_addr  out  AWIDTH  settings write address
- set_data  out  32  settings write data
- error_stb  out  1  one-cycle pulse on malformed packet
- busy  out  1  high while inside a packet (header accepted, tlast not yet accepted)

Behaviour:
- Reset and clocking:
  - Single clock domain; reset is synchronous and active-low, sampled on the rising edge of `clk`.
  - While `reset_n` = 0, all of the following are 0: `set_stb`, `set_addr`, `set_data`, `error_stb`, `busy`, `i_tready`, the gap counter, and the address register.
  - The state register is `S_HDR` during reset.
- Header word:
  - bits [AWIDTH-1:0] = start address.
  - bit 31 = AUTO_INC.
  - bits [30:AWIDTH] = reserved, must be 0.
- States:
  - `S_HDR` (expect header), `S_DATA` (write words), `S_DROP` (discard rest of bad packet).
- `S_HDR`:
  - `i_tready` = 1.
  - On header beat (tvalid & tready): latch address and AUTO_INC.
  - If `CHECK_RSVD` and reserved bits are nonzero: pulse `error_stb` next cycle, go to `S_DROP` (if that beat has tlast, stay in `S_HDR`).
  - Else, if tlast = 1 (header-only packet): pulse `error_stb`, no write, stay in `S_HDR`.
  - Else go to `S_DATA`.
  - The header beat never generates a strobe and does not start the gap counter.
- `S_DATA`:
  - `i_tready` = 1 iff the gap counter = 0.
  - On each data beat, in the next cycle: `set_stb` = 1, `set_addr` = current address, `set_data` = `i_tdata`.
  - Latency is exactly 1 cycle from beat to strobe.
  - After the beat, the address increments by 1 modulo 2^AWIDTH if AUTO_INC, else holds. Wrap from all-ones to 0 is legal and silent.
  - After the beat, the gap counter loads `STROBE_GAP`. It decrements each cycle while nonzero, so at most one strobe occurs per `STROBE_GAP`+1 cycles.
  - A beat with tlast returns to `S_HDR`. That next header may be accepted only once the gap counter is 0, via the normal `S_HDR` ready.
- `S_DROP`:
  - `i_tready` = 1; beats are discarded with no strobes.
  - tlast returns to `S_HDR`.
- `set_stb` and `error_stb` are registered single-cycle pulses and never coincide.
- `set_addr` and `set_data` hold their last written values between strobes.
- `busy` is a registered flag:
  - Set on acceptance of a header that does not carry tlast.
  - Cleared on acceptance of a tlast beat.
- Reset mid-packet:
  - Any partial packet is abandoned; no further strobes are issued.
  - The first beat after reset release is treated as a header. The upstream source must be reset together with this block.
- No combinational path from `i_tdata` to any output. `i_tready` depends only on state and the gap counter, never on `i_tvalid`.

Decomposition:
- Shared package `setting_bus_pkg`:
  - State enumeration (`S_HDR`, `S_DATA`, `S_DROP`).
  - Header field constants: AUTO_INC bit index 31, reserved-field upper bound 30.
  - Settings data width constant 32.
- The gap counter is a natural sub-module, `strobe_gap_counter`: load, decrement, zero flag, width clog2(`STROBE_GAP`+1). It is omitted when `STROBE_GAP` = 0.
- FSM and output registers are implemented inline.

Test Plan:
- Burst with increment (`STROBE_GAP`=0): header 0x8000_0010, data 0xA, 0xB, 0xC (last) -> strobes on consecutive cycles at addr 0x10/0x11/0x12 with data 0xA/0xB/0xC, each 1 cycle after its beat; `busy` high throughout, low after the last beat.
- Fixed address and throttling (`STROBE_GAP`=3): header 0x0000_0042, data 1, 2, 3 (last), tvalid held high -> three strobes all at addr 0x42, spaced exactly 4 cycles apart; `i_tready` low for 3 cycles after each data beat.
- Address wrap (AWIDTH=8): header 0x8000_00FE, four data words -> addresses 0xFE, 0xFF, 0x00, 0x01; no `error_stb`.
- Malformed headers:
  - Header 0x0100_0005 (reserved bit set), 2 data, last -> one `error_stb`, zero strobes, next packet processed normally.
  - Header-only packet with tlast -> `error_stb`, no strobe.
- Reset mid-packet: assert `reset_n`=0 after 1 of 3 data words -> outputs all 0 during reset, no further strobes; after release, word 0x8000_0020 is treated as a header and the following data writes to 0x20.
- Backpressure/idle: random tvalid gaps within a 5-word burst, `STROBE_GAP`=1 -> strobe count equals beat count, data order preserved, inter-strobe spacing ≥2 cycles.
